// File: rtl/frv_bram_bridge.sv
// Registered bridge from a core req/gnt + recv/ack memory port onto one BRAM port.
// Absorbs the BRAM's one-cycle read latency and buffers up to three responses for ack back-pressure.
module frv_bram_bridge #(
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] BRAM_SIZE = 32'h0001_0000
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  output logic        mem_gnt,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic        bram_cen,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic        bram_stall,
  input  logic [31:0] bram_rdata
);

  logic [31:0] offset;
  logic        in_range;
  logic        space;
  logic        accept;
  logic        push;
  logic        pop;
  logic        push_error;
  logic [31:0] push_data;

  logic        inflight_valid;
  logic        inflight_error;
  logic        inflight_wen;

  logic [1:0]  fifo_count;
  logic [1:0]  count_nxt;
  logic        fifo_err  [3];
  logic [31:0] fifo_data [3];
  logic        err_nxt   [3];
  logic [31:0] data_nxt  [3];

  assign offset   = mem_addr - BRAM_BASE;
  assign in_range = offset < BRAM_SIZE;
  assign space    = ({1'b0, fifo_count} + {2'b00, inflight_valid}) < 3'd3;

  assign bram_cen   = mem_req && in_range && space;
  assign bram_addr  = {offset[31:2], 2'b00};
  assign bram_wdata = mem_wdata;
  assign bram_wstrb = mem_wen ? mem_strb : 4'b0000;

  assign mem_gnt = space && (!in_range || !bram_stall);
  assign accept  = mem_req && mem_gnt;

  assign push       = inflight_valid;
  assign push_error = inflight_error;
  assign push_data  = (inflight_error || inflight_wen) ? '0 : bram_rdata;

  assign mem_recv  = fifo_count != 2'd0;
  assign pop       = mem_recv && mem_ack;
  assign mem_error = fifo_err[0];
  assign mem_rdata = fifo_data[0];

  // Shift-down FIFO: slot 0 is the registered head. Vacated slots are
  // refilled with zero so the head reads as zero whenever the FIFO is empty.
  always_comb begin
    err_nxt   = fifo_err;
    data_nxt  = fifo_data;
    count_nxt = fifo_count;
    if (pop) begin
      for (int unsigned i = 0; i < 2; i++) begin
        err_nxt[i]  = fifo_err[i + 1];
        data_nxt[i] = fifo_data[i + 1];
      end
      err_nxt[2]  = 1'b0;
      data_nxt[2] = '0;
      count_nxt   = fifo_count - 2'd1;
    end
    if (push) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (i == 32'(count_nxt)) begin
          err_nxt[i]  = push_error;
          data_nxt[i] = push_data;
        end
      end
      count_nxt = count_nxt + 2'd1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      inflight_valid <= 1'b0;
      inflight_error <= 1'b0;
      inflight_wen   <= 1'b0;
      fifo_count     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        fifo_err[i]  <= 1'b0;
        fifo_data[i] <= '0;
      end
    end else begin
      inflight_valid <= accept;
      inflight_error <= !in_range;
      inflight_wen   <= mem_wen;
      fifo_count     <= count_nxt;
      fifo_err       <= err_nxt;
      fifo_data      <= data_nxt;
    end
  end

endmodule
